// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the ID read ports and debug outputs of the register file.
// master: pipeline side (drives MEM/WB fields and read indices); slave: the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              WB_RegWrite;
  logic [1:0]        WB_MemtoReg;
  logic [4:0]        WB_Write_register;
  logic [DATA_W-1:0] WB_ALU_out;
  logic [DATA_W-1:0] WB_ReadData;
  logic [DATA_W-1:0] WB_PC_plus_4;
  logic [4:0]        Read_register1;
  logic [4:0]        Read_register2;
  logic [DATA_W-1:0] Read_data1;
  logic [DATA_W-1:0] Read_data2;
  logic [DATA_W-1:0] WB_Write_data;
  logic              WB_Commit;
  logic [CNT_W-1:0]  Commit_count;

  modport master (
    output WB_RegWrite, WB_MemtoReg, WB_Write_register,
    output WB_ALU_out, WB_ReadData, WB_PC_plus_4,
    output Read_register1, Read_register2,
    input  Read_data1, Read_data2, WB_Write_data, WB_Commit, Commit_count
  );

  modport slave (
    input  WB_RegWrite, WB_MemtoReg, WB_Write_register,
    input  WB_ALU_out, WB_ReadData, WB_PC_plus_4,
    input  Read_register1, Read_register2,
    output Read_data1, Read_data2, WB_Write_data, WB_Commit, Commit_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the 32x32 register file,
// and serves two write-first bypassed read ports plus a wrapping commit counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic [DATA_W-1:0] regs_q [1:REG_N-1];
  logic [DATA_W-1:0] regs_d [1:REG_N-1];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  always_comb begin
    wdata = '0;
    case (bus.WB_MemtoReg)
      2'b00:   wdata = bus.WB_ALU_out;
      2'b01:   wdata = bus.WB_ReadData;
      2'b10:   wdata = bus.WB_PC_plus_4;
      default: wdata = '0;
    endcase
  end

  assign commit = bus.WB_RegWrite && (bus.WB_Write_register != 5'd0)
                  && (bus.WB_MemtoReg != 2'b11);

  // Register 0 has no storage; only 1..REG_N-1 get a next-state decode.
  for (genvar gi = 1; gi < REG_N; gi++) begin : g_reg
    assign regs_d[gi] = (commit && bus.WB_Write_register == 5'(gi)) ? wdata : regs_q[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REG_N; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign cnt_d = commit ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (bus.Read_register1 != 5'd0) begin
      rd1 = (commit && bus.Read_register1 == bus.WB_Write_register)
            ? wdata : regs_q[bus.Read_register1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (bus.Read_register2 != 5'd0) begin
      rd2 = (commit && bus.Read_register2 == bus.WB_Write_register)
            ? wdata : regs_q[bus.Read_register2];
    end
  end

  assign bus.Read_data1    = rd1;
  assign bus.Read_data2    = rd2;
  assign bus.WB_Write_data = wdata;
  assign bus.WB_Commit     = commit;
  assign bus.Commit_count  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, source select, x0 handling, dual-port bypass, async reset.
module tb_wb_regfile;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();

  wb_regfile #(.DATA_W(32), .REG_N(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc);
    bus.WB_RegWrite       = we;
    bus.WB_MemtoReg       = sel;
    bus.WB_Write_register = dst;
    bus.WB_ALU_out        = alu;
    bus.WB_ReadData       = rdat;
    bus.WB_PC_plus_4      = pc;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 32; i++) begin
      bus.Read_register1 = 5'(i);
      bus.Read_register2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (bus.Read_data1 !== 32'd0 || bus.Read_data2 !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read idx=%0d got rd1=%h rd2=%h want 0", i, bus.Read_data1, bus.Read_data2);
      end
    end
    n_cmp++;
    if (bus.Commit_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_count got %0d want 0", bus.Commit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_bypass_write;
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd5, 32'h1234_5678, 32'h0, 32'h0);
    bus.Read_register1 = 5'd5;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'h1234_5678 || bus.WB_Commit !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_same_cycle got rd1=%h commit=%b want 12345678 1", bus.Read_data1, bus.WB_Commit);
    end
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'h1234_5678 || bus.Commit_count !== 32'd1) begin
      n_err++;
      $display("FAIL stored_reg5 got rd1=%h cnt=%0d want 12345678 1", bus.Read_data1, bus.Commit_count);
    end
    $display("test_bypass_write: reg5=%h count=%0d", bus.Read_data1, bus.Commit_count);
  endtask

  task automatic test_select_sweep;
    @(negedge clk);
    drive(1'b1, 2'b01, 5'd8, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222);
    #1;
    n_cmp++;
    if (bus.WB_Write_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL sel01_wdata got %h want deadbeef", bus.WB_Write_data);
    end
    @(negedge clk);
    drive(1'b1, 2'b10, 5'd31, 32'h1111_1111, 32'h3333_3333, 32'h0040_0010);
    #1;
    n_cmp++;
    if (bus.WB_Write_data !== 32'h0040_0010) begin
      n_err++;
      $display("FAIL sel10_wdata got %h want 00400010", bus.WB_Write_data);
    end
    @(negedge clk);
    drive(1'b1, 2'b11, 5'd9, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666);
    bus.Read_register1 = 5'd8;
    bus.Read_register2 = 5'd31;
    #1;
    n_cmp++;
    if (bus.WB_Write_data !== 32'd0 || bus.WB_Commit !== 1'b0) begin
      n_err++;
      $display("FAIL sel11_illegal got wdata=%h commit=%b want 0 0", bus.WB_Write_data, bus.WB_Commit);
    end
    n_cmp++;
    if (bus.Read_data1 !== 32'hDEAD_BEEF || bus.Read_data2 !== 32'h0040_0010) begin
      n_err++;
      $display("FAIL sweep_stored got r8=%h r31=%h want deadbeef 00400010", bus.Read_data1, bus.Read_data2);
    end
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    bus.Read_register1 = 5'd9;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'd0 || bus.Commit_count !== 32'd3) begin
      n_err++;
      $display("FAIL sel11_no_write got r9=%h cnt=%0d want 0 3", bus.Read_data1, bus.Commit_count);
    end
    $display("test_select_sweep: count=%0d", bus.Commit_count);
  endtask

  task automatic test_reg0;
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    bus.Read_register1 = 5'd0;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'd0 || bus.WB_Commit !== 1'b0 || bus.WB_Write_data !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL reg0_same_cycle got rd1=%h commit=%b wdata=%h want 0 0 ffffffff",
               bus.Read_data1, bus.WB_Commit, bus.WB_Write_data);
    end
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'd0 || bus.Commit_count !== 32'd3) begin
      n_err++;
      $display("FAIL reg0_after got rd1=%h cnt=%0d want 0 3", bus.Read_data1, bus.Commit_count);
    end
    $display("test_reg0: rd1=%h count=%0d", bus.Read_data1, bus.Commit_count);
  endtask

  task automatic test_dual_port;
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd12, 32'h1111_1111, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 2'b00, 5'd12, 32'hA5A5_A5A5, 32'h0, 32'h0);
    bus.Read_register1 = 5'd12;
    bus.Read_register2 = 5'd12;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'h1111_1111 || bus.Read_data2 !== 32'h1111_1111) begin
      n_err++;
      $display("FAIL no_bypass_old got rd1=%h rd2=%h want 11111111", bus.Read_data1, bus.Read_data2);
    end
    bus.WB_RegWrite = 1'b1;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'hA5A5_A5A5 || bus.Read_data2 !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL dual_bypass got rd1=%h rd2=%h want a5a5a5a5", bus.Read_data1, bus.Read_data2);
    end
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    bus.WB_ALU_out  = 32'h0;
    #1;
    n_cmp++;
    if (bus.Read_data2 !== 32'hA5A5_A5A5 || bus.Commit_count !== 32'd5) begin
      n_err++;
      $display("FAIL dual_stored got rd2=%h cnt=%0d want a5a5a5a5 5", bus.Read_data2, bus.Commit_count);
    end
    $display("test_dual_port: reg12=%h count=%0d", bus.Read_data2, bus.Commit_count);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd3, 32'h0000_0077, 32'h0, 32'h0);
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    bus.Read_register1 = 5'd3;
    bus.Read_register2 = 5'd12;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'h77 || bus.Commit_count !== 32'd6) begin
      n_err++;
      $display("FAIL pre_reset got r3=%h cnt=%0d want 77 6", bus.Read_data1, bus.Commit_count);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'd0 || bus.Read_data2 !== 32'd0 || bus.Commit_count !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset got r3=%h r12=%h cnt=%0d want 0 0 0",
               bus.Read_data1, bus.Read_data2, bus.Commit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'b00, 5'd3, 32'h0000_0099, 32'h0, 32'h0);
    @(negedge clk);
    bus.WB_RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (bus.Read_data1 !== 32'h99 || bus.Commit_count !== 32'd1) begin
      n_err++;
      $display("FAIL post_reset_write got r3=%h cnt=%0d want 99 1", bus.Read_data1, bus.Commit_count);
    end
    $display("test_async_reset: reg3=%h count=%0d", bus.Read_data1, bus.Commit_count);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    bus.Read_register1 = 5'd0;
    bus.Read_register2 = 5'd0;
    test_reset();
    test_bypass_write();
    test_select_sweep();
    test_reg0();
    test_dual_port();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register: consumes the WB_* control and data bundle, selects the write-back value and commits it to the 32x32 general register file.
- Provides the two decode-stage read ports with write-first bypass, so a value written back is visible to ID in the same cycle.
- Exports the selected write-back value for the EX forwarding unit and keeps a commit counter for debug and performance.

Parameters:
- DATA_W, 32, register and data width
- REG_N, 32, number of architectural registers (addressed by 5 bits)
- CNT_W, 32, width of the commit counter

Ports:
- clk  input  1  pipeline clock, rising edge active
- reset  input  1  asynchronous, active-high reset
- WB_RegWrite  input  1  write enable from MEM/WB
- WB_MemtoReg  input  2  write-back source select from MEM/WB
- WB_Write_register  input  5  destination register index
- WB_ALU_out  input  DATA_W  ALU result
- WB_ReadData  input  DATA_W  data-memory load result
- WB_PC_plus_4  input  DATA_W  link address for jal/jalr
- Read_register1  input  5  ID read port 1 index (rs)
- Read_register2  input  5  ID read port 2 index (rt)
- Read_data1  output  DATA_W  port 1 data, combinational
- Read_data2  output  DATA_W  port 2 data, combinational
- WB_Write_data  output  DATA_W  selected write-back value, combinational, for forwarding
- WB_Commit  output  1  high when the current WB cycle actually commits a register write
- Commit_count  output  CNT_W  number of committed writes since reset

Behaviour:
- Source mux, combinational:
  - MemtoReg 2'b00 selects WB_ALU_out.
  - 2'b01 selects WB_ReadData.
  - 2'b10 selects WB_PC_plus_4.
  - 2'b11 is an illegal encoding: WB_Write_data = 0 and the write is suppressed.
- WB_Commit = WB_RegWrite & (WB_Write_register != 0) & (WB_MemtoReg != 2'b11).
- Register array:
  - Registers 1..31 are flops.
  - Register 0 is not stored and always reads 0; writes to it are dropped.
- Write timing:
  - On the rising edge of clk with WB_Commit=1, reg[WB_Write_register] <= WB_Write_data.
  - Latency is 1 edge to storage.
  - No write occurs when WB_Commit=0.
- Read ports, combinational, write-first bypass:
  - Read_dataN = 0 if Read_registerN == 0.
  - Otherwise Read_dataN = WB_Write_data if WB_Commit and Read_registerN == WB_Write_register.
  - Otherwise Read_dataN = reg[Read_registerN].
  - Both ports may hit the bypass simultaneously and both return WB_Write_data.
- Commit counter:
  - Increments by 1 on each rising edge with WB_Commit=1.
  - Wraps modulo 2^CNT_W from all-ones to 0 with no saturation or flag.
- Reset (asynchronous, active-high):
  - Immediately clears all registers 1..31 and Commit_count to 0, independent of clk.
  - While reset is high, no write commits and the counter holds at 0.
  - Combinational outputs keep following their inputs. Because the MEM/WB register also drives RegWrite=0 under reset, WB_Commit=0 and the read ports return 0.
- Reset mid-operation: a write whose edge coincides with reset assertion is lost, and reset wins.
- After reset deasserts, the first rising edge with WB_Commit=1 performs a normal write.
- No stall or flush inputs: bubbles arrive as WB_RegWrite=0 from upstream.

Test Plan:
- Reset, then read all 32 indices on both ports -> every Read_data = 0; Commit_count = 0.
- WB_RegWrite=1, MemtoReg=00, dest=5, ALU_out=0x1234_5678; same cycle Read_register1=5 -> Read_data1 = 0x1234_5678 before the edge (bypass). After the edge, with RegWrite=0, Read_data1 = 0x1234_5678 from storage; Commit_count = 1.
- Select sweep, dest=8:
  - MemtoReg=01, ReadData=0xDEAD_BEEF -> reg8 = 0xDEAD_BEEF.
  - MemtoReg=10, PC_plus_4=0x0040_0010, dest=31 -> reg31 = 0x0040_0010.
  - MemtoReg=11, dest=9 -> reg9 unchanged, WB_Commit=0, count unchanged.
- Write dest=0 with ALU_out=0xFFFF_FFFF, RegWrite=1 -> Read_data1 with index 0 = 0 in the same cycle and after the edge; WB_Commit=0; Commit_count not incremented.
- Both ports index 12 while committing 0xA5A5_A5A5 to reg12 -> Read_data1 = Read_data2 = 0xA5A5_A5A5 in the same cycle. With RegWrite=0 and index 12, old data is returned instead.
- Load reg3 = 0x77. Assert reset asynchronously mid-cycle, between clock edges -> reg3 reads 0 immediately and Commit_count = 0. Deassert reset, then commit to reg3 -> new value stored, count = 1.
